psum_accum_quant: RTL and testbench

Downstream stage of dense_core. Consumes the 32-row psum_rows output once per output pixel and each IC pass. Accumulates the passes in an external dual-port PSUM SRAM using a pipelined read-modify-write. On the final pass it requantizes the 32-bit sums to int8 and streams the 32-channel result to the AXI output path.

---
 rtl/npu_psum_pkg.sv | 31 +++
 rtl/psum_requant_lane.sv | 57 +++++
 rtl/psum_accum_quant.sv | 219 +++++++++++++++++++++
 tb/tb_psum_accum_quant.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_psum_pkg.sv
// Shared widths, FSM encoding and rounding mode for the psum accumulate/requant stage.
// Imported by psum_accum_quant and psum_requant_lane.
package npu_psum_pkg;

    localparam int PSUM_BW    = 32;
    localparam int NUM_ROWS   = 32;
    localparam int OUT_BW     = 8;
    localparam int ADDR_PSUM  = 10;
    localparam int SCALE_BW   = 16;
    localparam int FIFO_DEPTH = 4;

    localparam int ROW_W   = PSUM_BW * NUM_ROWS;
    localparam int OUT_W   = OUT_BW * NUM_ROWS;
    localparam int PROD_BW = PSUM_BW + SCALE_BW;
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic {
        RND_TRUNC,
        RND_HALF_UP
    } rnd_mode_t;

    localparam rnd_mode_t QUANT_RND = RND_HALF_UP;

endpackage

// File: rtl/psum_requant_lane.sv
// One-lane requantizer: acc*scale, round half up, arithmetic shift, add zero point, clamp to int8.
// Ports: acc (signed psum), scale, shift, zero_point, q (int8); relu_en only with PSUM_RELU_EN.
module psum_requant_lane
    import npu_psum_pkg::*;
(
    input  logic [PSUM_BW-1:0]  acc,
    input  logic [SCALE_BW-1:0] scale,
    input  logic [4:0]          shift,
    input  logic [OUT_BW-1:0]   zero_point,
`ifdef PSUM_RELU_EN
    input  logic                relu_en,
`endif
    output logic [OUT_BW-1:0]   q
);

    localparam logic signed [PROD_BW:0] QMAX = 127;
    localparam logic signed [PROD_BW:0] QMIN = -128;

    logic [PSUM_BW-1:0]        a;
    logic signed [PROD_BW-1:0] a_ext;
    logic signed [PROD_BW-1:0] s_ext;
    logic signed [PROD_BW-1:0] prod;
    logic signed [PROD_BW-1:0] rnd;
    logic signed [PROD_BW-1:0] shifted;
    logic signed [PROD_BW:0]   biased;
    logic [4:0]                sh_m1;

`ifdef PSUM_RELU_EN
    assign a = (relu_en && acc[PSUM_BW-1]) ? '0 : acc;
`else
    assign a = acc;
`endif

    assign a_ext = {{SCALE_BW{a[PSUM_BW-1]}}, a};
    assign s_ext = {{PSUM_BW{scale[SCALE_BW-1]}}, scale};
    assign prod  = a_ext * s_ext;
    assign sh_m1 = shift - 5'd1;

    // Half-LSB bias only when bits are actually shifted out.
    assign rnd = (QUANT_RND == RND_HALF_UP && shift != 5'd0)
               ? ({{(PROD_BW-1){1'b0}}, 1'b1} << sh_m1)
               : '0;

    assign shifted = (prod + rnd) >>> shift;
    assign biased  = {shifted[PROD_BW-1], shifted}
                   + {{(PROD_BW+1-OUT_BW){zero_point[OUT_BW-1]}}, zero_point};

    always_comb begin
        q = biased[OUT_BW-1:0];
        if (biased > QMAX) begin
            q = 8'h7f;
        end else if (biased < QMIN) begin
            q = 8'h80;
        end
    end

endmodule

// File: rtl/psum_accum_quant.sv
// Accumulates IC-pass psums in an external dual-port SRAM and requantizes the last pass to int8.
// Ports: start/done job control, cfg (IMG_H/IMG_W/NUM_PASS/scale/shift/zero_point), psum valid/ready in,
// SRAM port B read / port A write, out valid/ready. Optional macro PSUM_RELU_EN adds relu_en.
module psum_accum_quant
    import npu_psum_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 done,
    input  logic [5:0]           IMG_H,
    input  logic [5:0]           IMG_W,
    input  logic [5:0]           NUM_PASS,
    input  logic [SCALE_BW-1:0]  scale,
    input  logic [4:0]           shift,
    input  logic [7:0]           zero_point,
`ifdef PSUM_RELU_EN
    input  logic                 relu_en,
`endif
    input  logic                 psum_valid,
    output logic                 psum_ready,
    input  logic [ROW_W-1:0]     psum_rows,
    output logic                 sram_rd_en,
    output logic [ADDR_PSUM-1:0] sram_rd_addr,
    input  logic [ROW_W-1:0]     sram_rd_data,
    output logic                 sram_wr_en,
    output logic [ADDR_PSUM-1:0] sram_wr_addr,
    output logic [ROW_W-1:0]     sram_wr_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data
);

    state_t              state;
    logic [11:0]         npix;
    logic [11:0]         pix_last;
    logic [11:0]         pix_cnt;
    logic [5:0]          pass_last;
    logic [5:0]          pass_cnt;
    logic [SCALE_BW-1:0] scale_q;
    logic [4:0]          shift_q;
    logic [7:0]          zp_q;
`ifdef PSUM_RELU_EN
    logic                relu_q;
`endif

    logic fire;
    logic on_last_pass;
    logic pix_wrap;
    logic room;

    logic                 s1_valid;
    logic                 s1_rd;
    logic                 s1_wr;
    logic                 s1_last;
    logic [ADDR_PSUM-1:0] s1_addr;
    logic [ROW_W-1:0]     s1_psum;
    logic [ROW_W-1:0]     base;
    logic [ROW_W-1:0]     sum;

    logic                 pw_valid;
    logic [ADDR_PSUM-1:0] pw_addr;
    logic [ROW_W-1:0]     pw_data;

    logic [OUT_W-1:0]     quant;
    logic [OUT_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     fifo_cnt;
    logic                 push;
    logic                 pop;

    assign npix         = {6'd0, IMG_H} * {6'd0, IMG_W};
    assign on_last_pass = (pass_cnt == pass_last);
    assign pix_wrap     = (pix_cnt == pix_last);

    // A last-pass beat reserves its FIFO slot at accept time, so
    // beats still in the pipe count against the free space.
    assign room = ({1'b0, fifo_cnt} + {{(FIFO_AW+1){1'b0}}, s1_valid & s1_last})
                < (FIFO_AW+2)'(FIFO_DEPTH);

    assign psum_ready   = (state == ST_RUN) && (!on_last_pass || room);
    assign fire         = psum_valid && psum_ready;
    assign sram_rd_en   = fire && (pass_cnt != 6'd0);
    assign sram_rd_addr = pix_cnt[ADDR_PSUM-1:0];

    // The SRAM returns old data when a read hits the address written
    // in the same cycle; take the just-written value instead.
    assign base = (pw_valid && pw_addr == s1_addr) ? pw_data : sram_rd_data;

    genvar r;
    generate
        for (r = 0; r < NUM_ROWS; r++) begin : g_lane
            assign sum[r*PSUM_BW +: PSUM_BW] = s1_rd
                ? base[r*PSUM_BW +: PSUM_BW] + s1_psum[r*PSUM_BW +: PSUM_BW]
                : s1_psum[r*PSUM_BW +: PSUM_BW];

            psum_requant_lane u_lane (
                .acc        (sum[r*PSUM_BW +: PSUM_BW]),
                .scale      (scale_q),
                .shift      (shift_q),
                .zero_point (zp_q),
`ifdef PSUM_RELU_EN
                .relu_en    (relu_q),
`endif
                .q          (quant[r*OUT_BW +: OUT_BW])
            );
        end
    endgenerate

    assign sram_wr_en   = s1_valid && s1_wr;
    assign sram_wr_addr = s1_addr;
    assign sram_wr_data = sram_wr_en ? sum : '0;

    assign push      = s1_valid && s1_last;
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo_mem[rd_ptr];
    assign done      = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pix_last  <= '0;
            pix_cnt   <= '0;
            pass_last <= '0;
            pass_cnt  <= '0;
            scale_q   <= '0;
            shift_q   <= '0;
            zp_q      <= '0;
`ifdef PSUM_RELU_EN
            relu_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pix_last  <= npix - 12'd1;
                        pass_last <= (NUM_PASS == 6'd0) ? 6'd0 : NUM_PASS - 6'd1;
                        scale_q   <= scale;
                        shift_q   <= shift;
                        zp_q      <= zero_point;
`ifdef PSUM_RELU_EN
                        relu_q    <= relu_en;
`endif
                        pix_cnt   <= '0;
                        pass_cnt  <= '0;
                        state     <= (npix == 12'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        if (pix_wrap) begin
                            pix_cnt  <= '0;
                            pass_cnt <= pass_cnt + 6'd1;
                            if (on_last_pass) begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            pix_cnt <= pix_cnt + 12'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!s1_valid && fifo_cnt == '0) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_rd    <= 1'b0;
            s1_wr    <= 1'b0;
            s1_last  <= 1'b0;
            s1_addr  <= '0;
            s1_psum  <= '0;
            pw_valid <= 1'b0;
            pw_addr  <= '0;
            pw_data  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            s1_valid <= fire;
            if (fire) begin
                s1_rd   <= (pass_cnt != 6'd0);
                s1_wr   <= !on_last_pass;
                s1_last <= on_last_pass;
                s1_addr <= pix_cnt[ADDR_PSUM-1:0];
                s1_psum <= psum_rows;
            end
            pw_valid <= sram_wr_en;
            pw_addr  <= s1_addr;
            pw_data  <= sum;
            if (push) begin
                fifo_mem[wr_ptr] <= quant;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum_quant.sv
// Scoreboard bench for psum_accum_quant: SRAM model, random/directed jobs, reference quant model.
// Connects relu_en only when PSUM_RELU_EN is defined.
module tb_psum_accum_quant;
    import npu_psum_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 done;
    logic [5:0]           IMG_H = '0;
    logic [5:0]           IMG_W = '0;
    logic [5:0]           NUM_PASS = '0;
    logic [SCALE_BW-1:0]  scale = '0;
    logic [4:0]           shift = '0;
    logic [7:0]           zero_point = '0;
    logic                 relu_en = 1'b0;
    logic                 psum_valid = 1'b0;
    logic                 psum_ready;
    logic [ROW_W-1:0]     psum_rows = '0;
    logic                 sram_rd_en;
    logic [ADDR_PSUM-1:0] sram_rd_addr;
    logic [ROW_W-1:0]     sram_rd_data = '0;
    logic                 sram_wr_en;
    logic [ADDR_PSUM-1:0] sram_wr_addr;
    logic [ROW_W-1:0]     sram_wr_data;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [OUT_W-1:0]     out_data;

    psum_accum_quant dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .done         (done),
        .IMG_H        (IMG_H),
        .IMG_W        (IMG_W),
        .NUM_PASS     (NUM_PASS),
        .scale        (scale),
        .shift        (shift),
        .zero_point   (zero_point),
`ifdef PSUM_RELU_EN
        .relu_en      (relu_en),
`endif
        .psum_valid   (psum_valid),
        .psum_ready   (psum_ready),
        .psum_rows    (psum_rows),
        .sram_rd_en   (sram_rd_en),
        .sram_rd_addr (sram_rd_addr),
        .sram_rd_data (sram_rd_data),
        .sram_wr_en   (sram_wr_en),
        .sram_wr_addr (sram_wr_addr),
        .sram_wr_data (sram_wr_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    always #5 clk = ~clk;

    // External dual-port SRAM: read-during-write returns old data.
    logic [ROW_W-1:0] sram [1024];
    always @(posedge clk) begin
        if (sram_wr_en) sram[sram_wr_addr] <= sram_wr_data;
        if (sram_rd_en) sram_rd_data <= sram[sram_rd_addr];
    end

    int checks = 0;
    int passes = 0;
    logic [OUT_W-1:0] exp_q[$];
    int acc_m [1024][NUM_ROWS];

    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
    int popped = 0, lp_acc = 0, max_out = 0;
    int stall_left = 0;
    bit rdy_rand = 0, in_last = 0, ready_dropped = 0;
    bit prev_stall = 0;
    logic [OUT_W-1:0] prev_data = '0;

    function automatic void chk(input bit ok, input string name,
                                input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    endfunction

    function automatic logic [7:0] qref(input int acc, input int sc, input int sh,
                                        input int zp, input bit relu);
        longint p;
        p = acc;
        if (relu && p < 0) p = 0;
        p = p * longint'(sc);
        if (sh > 0) p = p + (longint'(1) <<< (sh - 1));
        p = p >>> sh;
        p = p + zp;
        if (p > 127) p = 127;
        if (p < -128) p = -128;
        return p[7:0];
    endfunction

    // Output monitor: pops scoreboard on every handshake, checks hold under backpressure.
    always @(negedge clk) begin
        logic [OUT_W-1:0] e;
        if (!reset && prev_stall)
            chk(out_valid && out_data == prev_data, "out_hold", out_data, prev_data);
        if (!reset && out_valid && out_ready) begin
            popped++;
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_out", out_data, '0);
            end else begin
                e = exp_q.pop_front();
                chk(out_data == e, "out_beat", out_data, e);
            end
        end
        prev_stall = !reset && out_valid && !out_ready;
        prev_data  = out_data;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (sram_rd_en) rd_cnt++;
            if (sram_wr_en) wr_cnt++;
            if (done) done_cnt++;
            if (lp_acc - popped > max_out) max_out = lp_acc - popped;
            if (stall_left > 0 && in_last && psum_valid && !psum_ready) ready_dropped = 1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        bit ok;
        reset = 1'b1;
        psum_valid = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        ok = !done && !psum_ready && !sram_rd_en && !sram_wr_en && !out_valid
             && sram_rd_addr == '0 && sram_wr_addr == '0
             && sram_wr_data == '0 && out_data == '0;
        chk(ok, "reset_outs",
            OUT_W'({done, psum_ready, sram_rd_en, sram_wr_en, out_valid}), '0);
        reset = 1'b0;
        stall_left = 0;
        in_last = 0;
        exp_q.delete();
    endtask

    // vmode: 0 constant per pass from cv, 1 full-range random, 2 small random.
    task automatic run_job(input int h, input int w, input int np, input int sc,
                           input int sh, input int zp, input bit relu,
                           input int vmode, input int cv[4], input bit gaps,
                           input bit stall, input int abort_after);
        int npix, npe, r0, w0, d0, beats, v, n;
        logic [ROW_W-1:0] rows;
        logic [OUT_W-1:0] e;
        bit ok;
        npix = h * w;
        npe = (np == 0) ? 1 : np;
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        lp_acc = 0; popped = 0; max_out = 0; ready_dropped = 0;
        IMG_H = h[5:0]; IMG_W = w[5:0]; NUM_PASS = np[5:0];
        scale = sc[15:0]; shift = sh[4:0]; zero_point = zp[7:0];
        relu_en = relu;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        IMG_H = 6'($urandom); IMG_W = 6'($urandom); NUM_PASS = 6'($urandom);
        scale = 16'($urandom); shift = 5'($urandom); zero_point = 8'($urandom);
        relu_en = 1'($urandom);
        beats = 0;
        for (int p = 0; p < npe; p++) begin
            for (int i = 0; i < npix; i++) begin
                for (int l = 0; l < NUM_ROWS; l++) begin
                    case (vmode)
                        1: v = int'($urandom);
                        2: v = int'($urandom_range(0, 4000)) - 2000;
                        default: v = cv[p];
                    endcase
                    if (p == 0) acc_m[i][l] = v;
                    else acc_m[i][l] = acc_m[i][l] + v;
                    rows[l*PSUM_BW +: PSUM_BW] = v;
                    e[l*OUT_BW +: OUT_BW] = qref(acc_m[i][l], sc, sh, zp, relu);
                end
                if (p == npe - 1) exp_q.push_back(e);
                if (stall && p == npe - 1 && i == 0) begin
                    stall_left = 20;
                    in_last = 1;
                end
                if (gaps) begin
                    psum_valid = 1'b0;
                    n = $urandom_range(0, 2);
                    repeat (n) begin @(posedge clk); #1; end
                end
                psum_valid = 1'b1;
                psum_rows = rows;
                ok = 0;
                for (int k = 0; k < 1000; k++) begin
                    @(negedge clk);
                    if (psum_ready) begin ok = 1; break; end
                end
                @(posedge clk);
                #1;
                if (!ok) begin
                    chk(1'b0, "accept_timeout", OUT_W'(beats), OUT_W'(npix * npe));
                    do_reset();
                    return;
                end
                if (p == npe - 1) lp_acc++;
                beats++;
                if (beats == abort_after) begin
                    do_reset();
                    repeat (4) @(negedge clk);
                    chk(done_cnt == d0, "abort_no_done", OUT_W'(done_cnt - d0), '0);
                    @(posedge clk);
                    #1;
                    return;
                end
            end
        end
        psum_valid = 1'b0;
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        chk(ok, "done_seen", OUT_W'(ok), OUT_W'(1));
        repeat (2) @(negedge clk);
        chk(done_cnt - d0 == 1, "done_pulses", OUT_W'(done_cnt - d0), OUT_W'(1));
        chk(exp_q.size() == 0, "drained", OUT_W'(exp_q.size()), '0);
        chk(rd_cnt - r0 == npix * (npe - 1), "rd_count",
            OUT_W'(rd_cnt - r0), OUT_W'(npix * (npe - 1)));
        chk(wr_cnt - w0 == npix * (npe - 1), "wr_count",
            OUT_W'(wr_cnt - w0), OUT_W'(npix * (npe - 1)));
        if (stall) begin
            chk(max_out == FIFO_DEPTH, "stall_outstanding", OUT_W'(max_out), OUT_W'(FIFO_DEPTH));
            chk(ready_dropped, "stall_ready_drop", OUT_W'(ready_dropped), OUT_W'(1));
        end else begin
            chk(max_out <= FIFO_DEPTH, "max_outstanding", OUT_W'(max_out), OUT_W'(FIFO_DEPTH));
        end
        if (!ok) do_reset();
        in_last = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int h, w, np, sc, sh, zp;
        bit rl;
        repeat (2) @(posedge clk);
        #1;
        chk(!done && !psum_ready && !sram_rd_en && !sram_wr_en && !out_valid
            && sram_wr_data == '0 && out_data == '0 && sram_rd_addr == '0
            && sram_wr_addr == '0, "reset_state",
            OUT_W'({done, psum_ready, sram_rd_en, sram_wr_en, out_valid}), '0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_job(2, 2, 1, 1, 0, 0, 0, 0, '{5, 5, 5, 5}, 0, 0, -1);
        run_job(2, 2, 3, 3, 2, 0, 0, 0, '{100, -30, 7, 0}, 0, 0, -1);
        run_job(1, 1, 1, 1, 0, 10, 0, 0, '{1000, 0, 0, 0}, 0, 0, -1);
        run_job(1, 1, 1, 1, 0, 10, 0, 0, '{-1000, 0, 0, 0}, 0, 0, -1);
        run_job(1, 1, 4, 1, 0, 0, 0, 0, '{1, 1, 1, 1}, 0, 0, -1);
        run_job(2, 4, 2, 5, 3, -7, 0, 2, '{0, 0, 0, 0}, 0, 1, -1);
        run_job(2, 2, 3, 2, 1, 0, 0, 2, '{0, 0, 0, 0}, 0, 0, 6);
        run_job(2, 2, 3, 2, 1, 3, 0, 2, '{0, 0, 0, 0}, 0, 0, -1);
        run_job(0, 3, 2, 1, 0, 0, 0, 0, '{1, 1, 1, 1}, 0, 0, -1);

        rdy_rand = 1;
        for (int j = 0; j < 8; j++) begin
            h  = $urandom_range(1, 5);
            w  = $urandom_range(1, 5);
            np = $urandom_range(0, 4);
            sc = int'($urandom_range(0, 65535)) - 32768;
            sh = $urandom_range(0, 31);
            zp = int'($urandom_range(0, 255)) - 128;
            rl = 0;
`ifdef PSUM_RELU_EN
            rl = 1'($urandom);
`endif
            run_job(h, w, np, sc, sh, zp, rl, (j % 2) + 1, '{0, 0, 0, 0}, 1, 0, -1);
        end
        rdy_rand = 0;
        run_job(1, 2, 3, -1, 0, 0, 0, 2, '{0, 0, 0, 0}, 1, 0, -1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
